inverse_scale_2x2: RTL and testbench

Sequential back-end stage for the 2x2 matrix-inverse path. It accepts the adjugate elements and the determinant produced by the adjugate/determinant stage and divides each adjugate element by the determinant. A single shared serial restoring divider produces the four elements of the true inverse in signed fixed point. Singular matrices (det = 0) are flagged without dividing.

---
 rtl/inverse_scale_2x2.sv | 143 ++++++++++++++
 tb/tb_inverse_scale_2x2.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/inverse_scale_2x2.sv
// Back-end of the 2x2 inverse: divides four adjugate elements by the determinant
// through one shared serial restoring divider, producing signed Qx.FRAC results.
module inverse_scale_2x2 #(
  parameter int unsigned FRAC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        adj11,
  input  logic [3:0]        adj12,
  input  logic [3:0]        adj21,
  input  logic [3:0]        adj22,
  input  logic [7:0]        det,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC+4:0]   inv11,
  output logic [FRAC+4:0]   inv12,
  output logic [FRAC+4:0]   inv21,
  output logic [FRAC+4:0]   inv22,
  output logic              singular
);

  localparam int unsigned W    = FRAC + 5;
  localparam int unsigned N    = FRAC + 4;
  localparam int unsigned DETW = 8;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state, state_next;
  logic [3:0]      adj_r [4];
  logic [DETW-1:0] det_r;
  logic [1:0]      idx;
  logic [CW-1:0]   cnt;
  logic [DETW-1:0] rem;
  logic [N-1:0]    quo;
  logic [W-1:0]    inv_r [4];

  logic            accept_c, take_c, last_step_c, last_elem_c;
  logic [DETW-1:0] dmag_c;
  logic [DETW:0]   trial_c;
  logic            ge_c;
  logic [DETW-1:0] rem_next_c;
  logic [N-1:0]    quo_next_c;
  logic [W-1:0]    mag_c, result_c;
  logic            neg_c;

  // Unsigned dividend |a| << FRAC; |a| <= 8 always fits the N bits
  function automatic logic [N-1:0] dividend(input logic [3:0] a);
    logic [3:0] m;
    m = a[3] ? 4'(-a) : a;
    return {m, {FRAC{1'b0}}};
  endfunction

  assign accept_c    = in_valid && in_ready;
  assign take_c      = out_valid && out_ready;
  assign last_step_c = (cnt == CW'(N - 1));
  assign last_elem_c = (idx == 2'd3);

  // One restoring-division step on the current element
  always_comb begin
    dmag_c     = det_r[DETW-1] ? DETW'(-det_r) : det_r;
    trial_c    = {rem, quo[N-1]};
    ge_c       = (trial_c >= {1'b0, dmag_c});
    rem_next_c = ge_c ? DETW'(trial_c - {1'b0, dmag_c}) : DETW'(trial_c);
    quo_next_c = {quo[N-2:0], ge_c};
    mag_c      = W'(quo_next_c);
    neg_c      = adj_r[idx][3] ^ det_r[DETW-1];
    result_c   = neg_c ? W'(-mag_c) : mag_c;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept_c) state_next = (det == '0) ? DONE : DIV;
      DIV:  if (last_step_c && last_elem_c) state_next = DONE;
      DONE: if (take_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State plus handshake flags, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        adj_r[i] <= '0;
        inv_r[i] <= '0;
      end
      det_r    <= '0;
      idx      <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      singular <= 1'b0;
    end else if (accept_c) begin
      adj_r[0] <= adj11;
      adj_r[1] <= adj12;
      adj_r[2] <= adj21;
      adj_r[3] <= adj22;
      det_r    <= det;
      idx      <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= dividend(adj11);
      if (det == '0) begin
        singular <= 1'b1;
        for (int i = 0; i < 4; i++) inv_r[i] <= '0;
      end
    end else if (state == DIV) begin
      if (last_step_c) begin
        inv_r[idx] <= result_c;
        idx        <= idx + 2'd1;
        cnt        <= '0;
        rem        <= '0;
        quo        <= dividend(adj_r[idx + 2'd1]);
        if (last_elem_c) singular <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
        rem <= rem_next_c;
        quo <= quo_next_c;
      end
    end
  end

  assign inv11 = inv_r[0];
  assign inv12 = inv_r[1];
  assign inv21 = inv_r[2];
  assign inv22 = inv_r[3];

endmodule

// File: tb/tb_inverse_scale_2x2.sv
// Bench for inverse_scale_2x2: directed cases plus random matrices checked
// against an integer-division model of adj*2^FRAC/det.
module tb_inverse_scale_2x2;

  localparam int unsigned FRAC = 4;
  localparam int unsigned W    = FRAC + 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   adj11 = '0, adj12 = '0, adj21 = '0, adj22 = '0;
  logic [7:0]   det = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] inv11, inv12, inv21, inv22;
  logic         singular;

  int checks = 0;
  int errors = 0;

  inverse_scale_2x2 #(.FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .adj11(adj11), .adj12(adj12), .adj21(adj21), .adj22(adj22), .det(det),
    .out_valid(out_valid), .out_ready(out_ready),
    .inv11(inv11), .inv12(inv12), .inv21(inv21), .inv22(inv22),
    .singular(singular)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: integer division in SV truncates toward zero
  function automatic int model(input int a, input int d);
    if (d == 0) return 0;
    return (a * (1 << FRAC)) / d;
  endfunction

  function automatic int sv(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int a[4], input int d);
    check({tag, " inv11"}, sv(inv11), model(a[0], d));
    check({tag, " inv12"}, sv(inv12), model(a[1], d));
    check({tag, " inv21"}, sv(inv21), model(a[2], d));
    check({tag, " inv22"}, sv(inv22), model(a[3], d));
    check({tag, " singular"}, int'(singular), (d == 0) ? 1 : 0);
  endtask

  task automatic start(input int a[4], input int d);
    int guard = 0;
    while (!in_ready && guard < 200) begin tick(); guard++; end
    check("ready before accept", int'(in_ready), 1);
    adj11 = 4'(a[0]); adj12 = 4'(a[1]); adj21 = 4'(a[2]); adj22 = 4'(a[3]);
    det = 8'(d);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    adj11 = 4'($urandom); adj12 = 4'($urandom); adj21 = 4'($urandom);
    adj22 = 4'($urandom); det = 8'($urandom);
  endtask

  // Full transaction: accept, latency, results, optional backpressure, take
  task automatic run(input string tag, input int a[4], input int d, input int hold);
    int lat = 0;
    start(a, d);
    while (!out_valid && lat < 100) begin tick(); lat++; end
    check({tag, " latency"}, lat, (d == 0) ? 0 : 32);
    check_outputs(tag, a, d);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      tick();
      check({tag, " hold valid"}, int'(out_valid), 1);
      check({tag, " hold ready"}, int'(in_ready), 0);
      if (i == hold - 1) check_outputs({tag, " hold"}, a, d);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " valid drop"}, int'(out_valid), 0);
    check({tag, " ready back"}, int'(in_ready), 1);
  endtask

  initial begin
    int a[4];
    int d;
    repeat (3) tick();
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset inv11", sv(inv11), 0);
    rst_n = 1'b1;
    tick();

    a = '{1, -1, -1, 2};  run("identity-ish", a, 1, 0);
    a = '{4, -2, -3, 1};  run("neg det", a, -2, 0);
    a = '{1, -1, -8, 7};  run("truncate", a, 3, 0);
    a = '{-8, 7, 0, -8};  run("extreme", a, -1, 0);
    a = '{3, 3, 3, 3};    run("singular", a, 0, 0);
    a = '{2, -5, 6, -7};  run("after singular", a, 5, 0);
    a = '{5, 1, -2, 3};   run("backpressure", a, -7, 10);
    a = '{-3, 4, 1, -1};  run("post backpressure", a, 127, 0);
    a = '{-8, -8, 7, 7};  run("det min", a, -128, 0);

    // Reset during division discards the partial result
    a = '{7, 7, 7, 7};
    start(a, 1);
    repeat (11) tick();
    rst_n = 1'b0;
    #1;
    check("midreset in_ready", int'(in_ready), 1);
    check("midreset out_valid", int'(out_valid), 0);
    check("midreset singular", int'(singular), 0);
    check("midreset inv11", sv(inv11), 0);
    check("midreset inv22", sv(inv22), 0);
    tick();
    rst_n = 1'b1;
    tick();
    a = '{-1, 2, -3, 4};  run("after reset", a, 6, 0);

    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 4; k++) a[k] = int'($urandom_range(15)) - 8;
      d = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255)) - 128;
      run("random", a, d, int'($urandom_range(3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
